// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for memory_arbiter: FSM state encoding, grant IDs and the
// round-robin winner selection used in IDLE.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    // On a tie the port that was not served last wins.
    function automatic logic pick_winner(input logic i_req, input logic d_req,
                                         input logic last_grant);
        if (i_req && d_req) begin
            return ~last_grant;
        end
        if (d_req) begin
            return GRANT_DATA;
        end
        return GRANT_INSTR;
    endfunction

endpackage

// File: rtl/memory_arbiter_timeout.sv
// BUSY-cycle watchdog for memory_arbiter; only instantiated when
// MEMORY_ARBITER_TIMEOUT_EN is defined.
module arbiter_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    // Expires during the TIMEOUT_CYCLES-th consecutive enabled cycle.
    assign o_expired = i_enable && (r_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache refill port
// and the D-cache port. Optional BUSY timeout: define MEMORY_ARBITER_TIMEOUT_EN.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  iReq,
    input  logic [ADDR_WIDTH-1:0] iAddr,
    output logic                  iAck,
    output logic [DATA_WIDTH-1:0] iRData,
    output logic                  iErr,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [ADDR_WIDTH-1:0] dAddr,
    input  logic [DATA_WIDTH-1:0] dWData,
    output logic                  dAck,
    output logic [DATA_WIDTH-1:0] dRData,
    output logic                  dErr,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWData,
    input  logic                  memReady,
    input  logic [DATA_WIDTH-1:0] memRData,
    output logic                  grantData
);
    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic                  r_last_grant;
    logic                  r_grant;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_start;
    logic w_complete;
    logic w_timeout;
    logic w_expired;
    logic w_winner;
    logic w_resp;

    assign w_winner = pick_winner(iReq, dReq, r_last_grant);

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iReq || dReq) begin
                    w_start      = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A memReady coinciding with expiry is a normal completion.
                if (memReady) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_RESP;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_last_grant <= GRANT_DATA;
            r_grant      <= GRANT_INSTR;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            if (w_start) begin
                r_grant <= w_winner;
                r_we    <= (w_winner == GRANT_DATA) ? dWe : 1'b0;
                r_addr  <= (w_winner == GRANT_DATA) ? dAddr : iAddr;
                r_wdata <= (w_winner == GRANT_DATA) ? dWData : '0;
            end
            if (w_complete) begin
                r_rdata <= r_we ? '0 : memRData;
            end else if (w_timeout) begin
                r_rdata <= '0;
            end
            if (r_state == ST_RESP) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Memory side is driven from latched registers only, never live inputs.
    assign memReq    = (r_state == ST_BUSY);
    assign memWe     = memReq & r_we;
    assign memAddr   = r_addr;
    assign memWData  = r_wdata;
    assign grantData = r_grant;

    assign w_resp = (r_state == ST_RESP);
    assign iAck   = w_resp && (r_grant == GRANT_INSTR);
    assign dAck   = w_resp && (r_grant == GRANT_DATA);
    assign iRData = iAck ? r_rdata : '0;
    assign dRData = dAck ? r_rdata : '0;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    logic w_tmo_clear;
    logic w_tmo_enable;
    logic r_err;

    assign w_tmo_clear  = (r_state == ST_IDLE);
    assign w_tmo_enable = (r_state == ST_BUSY) && !memReady;

    arbiter_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .resetN   (resetN),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_err <= 1'b0;
        end else if (w_start || w_complete) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign iErr = iAck & r_err;
    assign dErr = dAck & r_err;
`else
    assign w_expired = 1'b0;
    assign iErr      = 1'b0;
    assign dErr      = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (inputs driven and outputs
// sampled on the falling clock edge).
module tb_memory_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          iReq = 1'b0;
    logic [AW-1:0] iAddr = '0;
    logic          iAck;
    logic [DW-1:0] iRData;
    logic          iErr;
    logic          dReq = 1'b0;
    logic          dWe = 1'b0;
    logic [AW-1:0] dAddr = '0;
    logic [DW-1:0] dWData = '0;
    logic          dAck;
    logic [DW-1:0] dRData;
    logic          dErr;
    logic          memReq;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWData;
    logic          memReady = 1'b0;
    logic [DW-1:0] memRData = '0;
    logic          grantData;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    memory_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .resetN(resetN),
        .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRData(iRData), .iErr(iErr),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData),
        .dAck(dAck), .dRData(dRData), .dErr(dErr),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memReady(memReady), .memRData(memRData), .grantData(grantData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        resetN = 1'b0;
        iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        memReady = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for memReq, holds it 'delay' cycles, then answers with rd.
    // Returns at the falling edge of the cycle in which the Ack is expected.
    task automatic mem_cycle(input int delay, input logic [DW-1:0] rd,
                             output logic [AW-1:0] addr, output logic we,
                             output logic [DW-1:0] wd, output logic stable,
                             output logic ok);
        int t;
        t = 0;
        while (!memReq && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = memReq;
        addr = memAddr; we = memWe; wd = memWData; stable = 1'b1;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            if (!memReq || memAddr !== addr || memWe !== we || memWData !== wd)
                stable = 1'b0;
        end
        memReady = 1'b1;
        memRData = rd;
        @(negedge clk);
        memReady = 1'b0;
        memRData = '0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        do_reset();
        got = {memReq, memWe, iAck, dAck, grantData, iErr | dErr};
        n_cmp++;
        if (got !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000", got);
        end
        n_cmp++;
        if (memAddr !== '0 || memWData !== '0) begin
            n_fail++;
            $display("FAIL reset_data: memAddr=%h memWData=%h required 0/0", memAddr, memWData);
        end
        $display("test_reset: ctrl=%b addr=%h", got, memAddr);
    endtask

    task automatic test_single_read();
        logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic st, ok;
        int t0;
        iReq = 1'b1; iAddr = 32'h100;
        t0 = cyc;
        @(negedge clk);
        mem_cycle(0, 32'hDEADBEEF, a, we, wd, st, ok);
        n_cmp++;
        if (!ok || a !== 32'h100 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL read_mem: ok=%b addr=%h we=%b required 1/00000100/0", ok, a, we);
        end
        n_cmp++;
        if (iAck !== 1'b1 || iRData !== 32'hDEADBEEF || dAck !== 1'b0 || (cyc - t0) != 2) begin
            n_fail++;
            $display("FAIL read_ack: iAck=%b iRData=%h dAck=%b edges=%0d required 1/deadbeef/0/2",
                     iAck, iRData, dAck, cyc - t0);
        end
        iReq = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (iAck !== 1'b0) begin
            n_fail++;
            $display("FAIL read_pulse: iAck=%b required 0", iAck);
        end
        $display("test_single_read: addr=%h rdata=%h", a, 32'hDEADBEEF);
    endtask

    task automatic test_tie();
        logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic st, ok;
        do_reset();
        iReq = 1'b1; iAddr = 32'h200;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h300;
        @(negedge clk);
        mem_cycle(0, 32'h0000AAAA, a, we, wd, st, ok);
        n_cmp++;
        if (!ok || a !== 32'h200 || iAck !== 1'b1 || dAck !== 1'b0 || iRData !== 32'h0000AAAA) begin
            n_fail++;
            $display("FAIL tie_first: addr=%h iAck=%b dAck=%b iRData=%h required 00000200/1/0/0000aaaa",
                     a, iAck, dAck, iRData);
        end
        $display("tie txn1: addr=%h iAck=%b dAck=%b", a, iAck, dAck);
        mem_cycle(0, 32'h0000BBBB, a, we, wd, st, ok);
        n_cmp++;
        if (!ok || a !== 32'h300 || dAck !== 1'b1 || iAck !== 1'b0 || dRData !== 32'h0000BBBB) begin
            n_fail++;
            $display("FAIL tie_second: addr=%h dAck=%b iAck=%b dRData=%h required 00000300/1/0/0000bbbb",
                     a, dAck, iAck, dRData);
        end
        $display("tie txn2: addr=%h iAck=%b dAck=%b", a, iAck, dAck);
        iReq = 1'b0; dReq = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_slow();
        logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic st, ok;
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h40; dWData = 32'h1234;
        @(negedge clk);
        mem_cycle(5, 32'hFFFFFFFF, a, we, wd, st, ok);
        n_cmp++;
        if (!ok || a !== 32'h40 || we !== 1'b1 || wd !== 32'h1234 || st !== 1'b1) begin
            n_fail++;
            $display("FAIL write_mem: addr=%h we=%b wd=%h stable=%b required 00000040/1/00001234/1",
                     a, we, wd, st);
        end
        n_cmp++;
        if (dAck !== 1'b1 || dRData !== '0 || dErr !== 1'b0 || iAck !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ack: dAck=%b dRData=%h dErr=%b iAck=%b required 1/0/0/0",
                     dAck, dRData, dErr, iAck);
        end
        dReq = 1'b0; dWe = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dAck !== 1'b0) begin
            n_fail++;
            $display("FAIL write_pulse: dAck=%b required 0", dAck);
        end
        $display("test_write_slow: addr=%h wdata=%h stable=%b", a, wd, st);
    endtask

    task automatic test_reset_busy();
        logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic st, ok;
        int acks;
        iReq = 1'b1; iAddr = 32'h500;
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        n_cmp++;
        if (memReq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: memReq=%b required 0", memReq);
        end
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (iAck || dAck) acks++;
        end
        n_cmp++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL reset_noack: acks=%0d required 0", acks);
        end
        resetN = 1'b1;
        @(negedge clk);
        mem_cycle(0, 32'h00005555, a, we, wd, st, ok);
        n_cmp++;
        if (!ok || a !== 32'h500 || iAck !== 1'b1 || iRData !== 32'h00005555) begin
            n_fail++;
            $display("FAIL reset_resume: addr=%h iAck=%b iRData=%h required 00000500/1/00005555",
                     a, iAck, iRData);
        end
        iReq = 1'b0;
        @(negedge clk);
        $display("test_reset_busy: resumed addr=%h", a);
    endtask

    task automatic test_stray_ready();
        int bad;
        bad = 0;
        memReady = 1'b1; memRData = 32'h99;
        repeat (3) begin
            @(negedge clk);
            if (memReq || iAck || dAck) bad++;
        end
        memReady = 1'b0; memRData = '0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stray_ready: bad cycles=%0d required 0", bad);
        end
        $display("test_stray_ready: bad=%0d", bad);
    endtask

    task automatic test_timeout();
        int k;
        int acks;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h80;
        @(negedge clk);
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        k = 0;
        while (memReq && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL timeout_len: busy=%0d required 4", k);
        end
        n_cmp++;
        if (dAck !== 1'b1 || dErr !== 1'b1 || dRData !== '0 || iErr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_ack: dAck=%b dErr=%b dRData=%h iErr=%b required 1/1/0/0",
                     dAck, dErr, dRData, iErr);
        end
        dReq = 1'b0;
        @(negedge clk);
        $display("test_timeout: busy=%0d dErr=1 expected", k);
`else
        acks = 0;
        k = 0;
        repeat (100) begin
            @(negedge clk);
            if (iAck || dAck || iErr || dErr) acks++;
            if (memReq) k++;
        end
        n_cmp++;
        if (memReq !== 1'b1 || acks != 0 || k != 100) begin
            n_fail++;
            $display("FAIL no_timeout: memReq=%b acks=%0d busy=%0d required 1/0/100",
                     memReq, acks, k);
        end
        $display("test_timeout: still busy after %0d cycles", k);
        do_reset();
`endif
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a; logic we; logic [DW-1:0] wd; logic st, ok;
        logic          exp_g [4];
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        iReq = 1'b1; iAddr = 32'h600;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h700;
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            mem_cycle(1, 32'h1000 + n, a, we, wd, st, ok);
            n_cmp++;
            if (!ok || dAck !== exp_g[n] || iAck !== !exp_g[n] ||
                a !== (exp_g[n] ? 32'h700 : 32'h600)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: addr=%h iAck=%b dAck=%b required dAck=%b",
                         n, a, iAck, dAck, exp_g[n]);
            end
            $display("rr txn%0d: addr=%h iAck=%b dAck=%b", n, a, iAck, dAck);
            if (dAck) begin
                dReq = 1'b0;
                @(negedge clk);
                dReq = 1'b1;
            end
        end
        iReq = 1'b0; dReq = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_write_slow();
        test_reset_busy();
        test_stray_ready();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
